// File: rtl/sync_fifo_wrapper_pkg.sv
// Shared definitions for the first-word-fall-through FIFO.
//   - Default geometry for instances that do not override WIDTH/DEPTH.
//   - Encoding of the per-cycle FIFO operation (push, pop, both or none),
//     used by the control logic to pick pointer and occupancy updates.
package sync_fifo_wrapper_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 128;

  // Bit 0 = push, bit 1 = pop, so the encoding is just {pop, push}.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/sync_fifo_wrapper_ram.sv
// Storage array for sync_fifo_wrapper.
// Simple dual-port memory: synchronous write, asynchronous read, no reset.
// Ports:
//   clk_i    write clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
module sync_fifo_wrapper_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left uncleared on reset; the control logic
  // never exposes an entry that has not been written since reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_wrapper.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Buffers a byte stream between a producer and a consumer so that stalls on
// one side do not propagate combinationally to the other.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset; flushes all buffered words
//   input_data    write-side data
//   input_valid   write-side data valid
//   input_ready   FIFO can accept a word (low while full or in reset)
//   output_data   word at the FIFO head, zero when empty
//   output_valid  FIFO holds at least one word
//   output_ready  consumer accepts the head word
module sync_fifo_wrapper
  import sync_fifo_wrapper_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic             full, empty;
  logic             push, pop;
  fifo_op_e         op;
  logic [WIDTH-1:0] head_data;

  // Status depends only on registered occupancy, so there is no
  // combinational path from output_ready to input_ready, nor from
  // input_valid to output_valid.
  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);

  always_comb begin
    input_ready  = !reset && !full;
    output_valid = !empty;
    output_data  = output_valid ? head_data : '0;
  end

  assign push = input_valid && input_ready;
  assign pop  = output_valid && output_ready;
  assign op   = decode_op(push, pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    unique case (op)
      OpPush: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CntW'(1);
      end
      OpPop: begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d  = count_q - CntW'(1);
      end
      // Both only happens with 0 < count < DEPTH, so the addresses differ
      // and occupancy is unchanged.
      OpBoth: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      OpNone: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  sync_fifo_wrapper_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AddrW (PtrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (input_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  a_count_bound : assert property (@(posedge clk) disable iff (reset) count_q <= FullCnt);
  a_no_push_full : assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: tb/tb_sync_fifo_wrapper.sv
// Self-checking bench for sync_fifo_wrapper (WIDTH = 8, DEPTH = 128).
// A queue-based reference model predicts ready/valid/head data each cycle.
module tb_sync_fifo_wrapper;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 128;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] input_data = '0;
  logic             input_valid = 1'b0;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_wrapper #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [WIDTH-1:0] model_q[$];

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             rdy;
    logic             vld;
    logic [WIDTH-1:0] dat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge. Drives inputs, compares outputs with
  // the model, clocks once, then applies the accepted transfers to the model.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    logic exp_ready;
    logic exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic do_push;
    logic do_pop;
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
    #1;
    exp_ready = (model_q.size() < int'(DEPTH));
    exp_valid = (model_q.size() != 0);
    exp_data  = exp_valid ? model_q[0] : '0;
    check("input_ready", 32'(input_ready), 32'(exp_ready));
    check("output_valid", 32'(output_valid), 32'(exp_valid));
    check("output_data", 32'(output_data), 32'(exp_data));
    do_push = iv && exp_ready;
    do_pop  = ordy && exp_valid;
    @(posedge clk);
    if (do_pop) begin
      void'(model_q.pop_front());
      n_popped++;
    end
    if (do_push) begin
      model_q.push_back(d);
      n_pushed++;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int base;
    int guard;
    int words;

    // Ordered streaming with FWFT timing: pushes then drain.
    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

    // Reset held for 10 cycles.
    for (int r = 0; r < 10; r++) begin
      @(posedge clk);
      #1;
      check("reset input_ready", 32'(input_ready), 32'd0);
      check("reset output_valid", 32'(output_valid), 32'd0);
      check("reset output_data", 32'(output_data), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("release input_ready", 32'(input_ready), 32'd1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) begin
      input_valid  = vecs[i].iv;
      input_data   = vecs[i].d;
      output_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d input_ready", i), 32'(input_ready), 32'(vecs[i].rdy));
      check($sformatf("vec%0d output_valid", i), 32'(output_valid), 32'(vecs[i].vld));
      check($sformatf("vec%0d output_data", i), 32'(output_data), 32'(vecs[i].dat));
      @(posedge clk);
      #1;
    end

    // Fill to full, ignored extra push, then push+pop while full.
    for (int f = 0; f < int'(DEPTH); f++) cycle(1'b1, 8'(f), 1'b0);
    check("full input_ready", 32'(input_ready), 32'd0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    check("ready after full pop", 32'(input_ready), 32'd1);
    words = 0;
    guard = 0;
    while (output_valid && guard < 300) begin
      cycle(1'b0, 8'h00, 1'b1);
      words++;
      guard++;
    end
    check("words after full pop", 32'(words), 32'd127);

    // Random concurrent traffic; 1000 accepted words wrap pointers ~8 times.
    base  = n_pushed;
    guard = 0;
    while ((n_pushed - base) < 1000 && guard < 20000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      guard++;
    end
    check("random words accepted", 32'((n_pushed - base) >= 1000), 32'd1);
    guard = 0;
    while (model_q.size() != 0 && guard < 500) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    check("random drained", 32'(output_valid), 32'd0);

    // Reset mid-stream with 40 words buffered, asserted between edges.
    for (int m = 0; m < 40; m++) cycle(1'b1, 8'(m + 100), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async reset output_valid", 32'(output_valid), 32'd0);
    check("async reset input_ready", 32'(input_ready), 32'd0);
    check("async reset output_data", 32'(output_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    cycle(1'b1, 8'h7E, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
